// File: rtl/mips_seq_pkg.sv
// Shared types and helpers for the branch/PC sequencer: state encoding, PC step, offset extension.
package mips_seq_pkg;

  typedef enum logic {
    StRun   = 1'b0,
    StBrTgt = 1'b1
  } seq_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  // Sign-extend a 16-bit word offset, optionally converting it to a byte offset.
  function automatic logic [31:0] sext_shift(input logic [15:0] imm, input logic shl2);
    logic [31:0] ext;
    ext = {{16{imm[15]}}, imm};
    return shl2 ? {ext[29:0], 2'b00} : ext;
  endfunction

endpackage

// File: rtl/branch_pc_sequencer_if.sv
// Decode-to-fetch bundle: decode control/immediates in, fetch PC and redirect status out.
interface branch_pc_sequencer_if;

  logic        stall;
  logic        dec_valid;
  logic        is_branch;
  logic        br_taken;
  logic        is_jump;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic        dec_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        busy;

  modport master (
    output stall, dec_valid, is_branch, br_taken, is_jump, imm16, jidx,
    input  dec_ready, pc, pc_plus4, flush, busy
  );

  modport slave (
    input  stall, dec_valid, is_branch, br_taken, is_jump, imm16, jidx,
    output dec_ready, pc, pc_plus4, flush, busy
  );

endinterface

// File: rtl/shift_add32.sv
// Combinational adder with optional left-shift-by-2 on the second operand.
module shift_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        shift,
  output logic [31:0] sum
);

  assign sum = a + (shift ? {b[29:0], 2'b00} : b);

endmodule

// File: rtl/branch_pc_sequencer.sv
// Fetch PC owner: sequential increment, one-cycle jumps, two-cycle taken branches on a shared adder.
module branch_pc_sequencer
  import mips_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_pc_sequencer_if.slave bus
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [15:0]     imm_q, imm_d;
  logic            flush_q, flush_d;
  logic            pc_load;
  logic            accept;
  logic [XLEN-1:0] add_a, add_b, sum;
  logic            add_shift;
  logic [XLEN-1:0] jump_target;

  assign accept      = bus.dec_valid & bus.dec_ready;
  assign jump_target = {pc_plus4_q[31:28], bus.jidx, 2'b00};

  // Adder operand select: PC increment in RUN, branch target in BR_TGT.
  always_comb begin
    add_a     = pc_q;
    add_b     = PC_INC;
    add_shift = 1'b0;
    if (state_q == StBrTgt) begin
      add_a     = pc_plus4_q;
      add_b     = sext_shift(imm_q, 1'b0);
      add_shift = 1'b1;
    end
  end

  shift_add32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .shift(add_shift),
    .sum  (sum)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    imm_d      = imm_q;
    flush_d    = 1'b0;
    pc_load    = 1'b0;
    if (!bus.stall) begin
      unique case (state_q)
        StRun: begin
          if (accept && bus.is_jump) begin
            pc_d    = jump_target;
            pc_load = 1'b1;
            flush_d = 1'b1;
          end else if (accept && bus.is_branch && bus.br_taken) begin
            imm_d   = bus.imm16;
            state_d = StBrTgt;
          end else begin
            pc_d    = sum;
            pc_load = 1'b1;
          end
        end
        StBrTgt: begin
          pc_d    = sum;
          pc_load = 1'b1;
          flush_d = 1'b1;
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
    // pc_plus4 always tracks pc + 4 so a following branch can use it as its base.
    if (pc_load) begin
      pc_plus4_d = pc_d + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + PC_INC;
      imm_q      <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      imm_q      <= imm_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.dec_ready = (state_q == StRun) & ~bus.stall;
  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4_q;
  assign bus.flush     = flush_q & ~bus.stall;
  assign bus.busy      = (state_q == StBrTgt);

endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
Owns the fetch PC and schedules one shared 32-bit add-with-shift unit between two uses: sequential increment (PC+4) and branch target computation (PC+4 + (sext(imm16)<<2)). Taken branches take two cycles because the adder is shared. Jumps redirect in one cycle. The block sits between decode (branch/jump indications) and instruction fetch (PC output).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, datapath width; only 32 is supported

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
stall  in  1  global pipeline stall; freezes all state
dec_valid  in  1  decode presents a valid instruction this cycle
is_branch  in  1  instruction is a conditional branch
br_taken  in  1  branch condition resolved true; qualified by is_branch
is_jump  in  1  instruction is J/JAL
imm16  in  16  branch offset in words
jidx  in  26  jump index field
dec_ready  out  1  sequencer accepts decode info this cycle
pc  out  32  current fetch PC
pc_plus4  out  32  registered PC+4 of the last accepted instruction, for link
flush  out  1  one-cycle pulse: discard the wrong-path fetch
busy  out  1  high while in BR_TGT

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC, pc_plus4=RESET_PC+4, state=RUN, flush=0, busy=0. The reset result is independent of stall and of the current state, including mid-BR_TGT.
- States: RUN, BR_TGT.
- dec_ready=1 in RUN when stall=0; otherwise 0. busy=1 only in BR_TGT.
- RUN, adder operands A=pc, B=4. An "accept" is dec_valid & dec_ready. At the posedge:
  - no accept: pc<=pc+4; pc_plus4<=pc+8.
  - accept, is_jump=1: pc<={pc_plus4[31:28], jidx, 2'b00}; flush<=1; stay in RUN.
  - accept, is_branch & br_taken (with is_jump=0): latch imm16; pc held; go to BR_TGT.
  - accept, not-taken branch or other instruction: same as no accept.
- BR_TGT, adder operands A=pc_plus4 (latched), B=sext(imm16)<<2. At the posedge: pc<=sum; pc_plus4<=sum+4; flush<=1; go to RUN. Total latency is 2 cycles from accept to the redirected PC.
- If is_jump and is_branch are both set, the jump wins and the branch is ignored.
- stall=1: pc, pc_plus4, state and the latched imm hold. flush is forced 0 while stalled. A pending BR_TGT completes on the first unstalled cycle.
- Arithmetic is modulo 2^32. Wrap-around is silent (0xFFFF_FFFC + 4 = 0). Negative offsets are sign-extended before the shift. pc[1:0] is always 00.
- flush is high for exactly one cycle per redirect and is never high in two consecutive cycles.

Decomposition:
- Shared package/header mips_seq_pkg:
  - state encoding (RUN=1'b0, BR_TGT=1'b1)
  - PC_INC=32'd4
  - sign-extend-and-shift helper function
- One sub-module, shift_add32: combinational sum = a + (shift ? b<<2 : b), with b sign-extended at the caller. It is instantiated once, and its operands are selected by state.

Test Plan:
1. Reset release, then 4 free cycles with RESET_PC=0 -> pc = 0, 4, 8, 0xC; pc_plus4 = 4, 8, 0xC, 0x10.
2. Forward taken branch: pc=0x100, accept branch, imm16=0x0003, taken -> cycle 1: busy=1, pc=0x100; cycle 2: pc=0x110, flush=1, pc_plus4=0x114.
3. Backward taken branch: pc=0x100, imm16=0xFFFE -> pc=0xFC after 2 cycles. Not-taken branch at the same pc -> pc=0x104 next cycle, flush=0.
4. Jump: pc=0x4000_0000, jidx=0x0000_040 -> pc=0x4000_0100 the next cycle, flush=1. With is_branch also set, the result is identical (jump priority).
5. Stall in BR_TGT for 3 cycles -> pc, busy and imm hold; flush=0 throughout; the redirect lands on the first unstalled edge.
6. Edge cases:
   - rst_n=0 during BR_TGT -> next cycle pc=RESET_PC, state RUN, no flush.
   - pc=0xFFFF_FFFC free-running -> pc wraps to 0x0.
